// File: rtl/alarm_control_unit_n.sv
// alarm_control_unit_n: arbitrates NUM_ALARMS alarm flags into one buzzer with snooze, ring timeout and lockout.
// Optional ALARM_BEEP_EN makes Sound pulse 1 s on / 1 s off while ringing.
module alarm_control_unit_n #(
  parameter int NUM_ALARMS   = 2,
  parameter int SNOOZE_TICKS = 300,
  parameter int RING_TIMEOUT = 60,
  parameter int MAX_SNOOZE   = 3,
  localparam int IW = NUM_ALARMS > 1 ? $clog2(NUM_ALARMS) : 1,
  localparam int SW = MAX_SNOOZE > 0 ? $clog2(MAX_SNOOZE + 1) : 1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Tick,
  input  logic [NUM_ALARMS-1:0] AA,
  input  logic                  Mute,
  input  logic                  Snooze,
  input  logic                  Stop,
  output logic                  Sound,
  output logic                  EN_SNZ,
  output logic                  EN_STOP,
  output logic [IW-1:0]         Active_Id,
  output logic [SW-1:0]         Snooze_Cnt,
  output logic                  Missed
);
  localparam int RW = RING_TIMEOUT > 1 ? $clog2(RING_TIMEOUT) : 1;
  localparam int TW = $clog2(SNOOZE_TICKS + 1);
  localparam logic [SW-1:0] SMAX = SW'(MAX_SNOOZE);
  localparam logic [RW-1:0] RMAX = RW'(RING_TIMEOUT - 1);
  localparam logic [TW-1:0] STK  = TW'(SNOOZE_TICKS);
  typedef enum logic [1:0] {IDLE, RING, SNOOZE, LOCK} state_t;
  state_t r_state, w_nstate;
  logic [IW-1:0] r_id, w_id_nxt, w_low;
  logic [SW-1:0] r_scnt, w_scnt_nxt;
  logic [RW-1:0] r_rcnt, w_rcnt_nxt;
  logic [TW-1:0] r_stmr, w_stmr_nxt;
  logic r_snz_q, r_stp_q, w_snz_p, w_stp_p, w_miss, w_sound_nxt;
  logic r_sound, r_en_snz, r_en_stop, r_missed;
  assign w_snz_p = Snooze & ~r_snz_q;
  assign w_stp_p = Stop & ~r_stp_q;
  always_comb begin
    w_low = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--)
      if (AA[i]) w_low = IW'(i);
  end
  always_comb begin
    w_nstate   = r_state;
    w_id_nxt   = r_id;
    w_scnt_nxt = r_scnt;
    w_rcnt_nxt = r_rcnt;
    w_stmr_nxt = r_stmr;
    w_miss     = 1'b0;
    case (r_state)
      IDLE:
        if (!Mute && |AA) begin
          w_nstate   = RING;
          w_id_nxt   = w_low;
          w_scnt_nxt = '0;
          w_rcnt_nxt = '0;
        end
      RING:
        if (w_stp_p) w_nstate = LOCK;
        else if (w_snz_p && r_scnt < SMAX) begin
          w_nstate   = SNOOZE;
          w_scnt_nxt = r_scnt + 1'b1;
          w_stmr_nxt = STK;
        end else if (Tick) begin
          if (r_rcnt == RMAX) begin
            w_nstate = LOCK;
            w_miss   = 1'b1;
          end else w_rcnt_nxt = r_rcnt + 1'b1;
        end
      SNOOZE:
        if (w_stp_p) w_nstate = LOCK;
        else if (Tick) begin
          if (r_stmr == TW'(1)) begin
            w_nstate   = RING;
            w_rcnt_nxt = '0;
          end else w_stmr_nxt = r_stmr - 1'b1;
        end
      default:
        if (!AA[r_id]) w_nstate = IDLE;
    endcase
  end
`ifdef ALARM_BEEP_EN
  // r_sound doubles as the beep phase: forced high on RING entry, toggled by each Tick while ringing
  assign w_sound_nxt = w_nstate == RING && (r_state != RING || (Tick ? !r_sound : r_sound));
`else
  assign w_sound_nxt = w_nstate == RING;
`endif
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state   <= IDLE;
      r_id      <= '0;
      r_scnt    <= '0;
      r_rcnt    <= '0;
      r_stmr    <= '0;
      r_snz_q   <= 1'b0;
      r_stp_q   <= 1'b0;
      r_sound   <= 1'b0;
      r_en_snz  <= 1'b0;
      r_en_stop <= 1'b0;
      r_missed  <= 1'b0;
    end else begin
      r_state   <= w_nstate;
      r_id      <= w_id_nxt;
      r_scnt    <= w_scnt_nxt;
      r_rcnt    <= w_rcnt_nxt;
      r_stmr    <= w_stmr_nxt;
      r_snz_q   <= Snooze;
      r_stp_q   <= Stop;
      r_sound   <= w_sound_nxt;
      r_en_snz  <= w_nstate == RING && w_scnt_nxt < SMAX;
      r_en_stop <= w_nstate == RING || w_nstate == SNOOZE;
      r_missed  <= w_miss;
    end
  end
  assign Sound      = r_sound;
  assign EN_SNZ     = r_en_snz;
  assign EN_STOP    = r_en_stop;
  assign Active_Id  = r_id;
  assign Snooze_Cnt = r_scnt;
  assign Missed     = r_missed;
endmodule

// File: tb/tb_alarm_control_unit_n.sv
// tb_alarm_control_unit_n: directed stimulus with a cycle-tagged expectation queue checked by a separate monitor.
module tb_alarm_control_unit_n;
`ifdef ALARM_BEEP_EN
  localparam bit BEEP = 1'b1;
`else
  localparam bit BEEP = 1'b0;
`endif
  localparam bit MB = !BEEP;
  logic Clk = 1'b0, Reset = 1'b1, Tick = 1'b0, Mute = 1'b0, Snooze = 1'b0, Stop = 1'b0;
  logic [1:0] AA = 2'b00;
  logic Sound, EN_SNZ, EN_STOP, Missed;
  logic [0:0] Active_Id;
  logic [1:0] Snooze_Cnt;
  int cyc = 0, checks = 0, errors = 0;
  typedef struct {
    int cyc;
    string nm;
    logic [5:0] mask;
    logic [5:0] want;
  } exp_t;
  exp_t q[$];
  exp_t e;
  alarm_control_unit_n #(.NUM_ALARMS(2), .SNOOZE_TICKS(4), .RING_TIMEOUT(5), .MAX_SNOOZE(3)) dut (
    .Clk(Clk), .Reset(Reset), .Tick(Tick), .AA(AA), .Mute(Mute), .Snooze(Snooze), .Stop(Stop),
    .Sound(Sound), .EN_SNZ(EN_SNZ), .EN_STOP(EN_STOP), .Active_Id(Active_Id),
    .Snooze_Cnt(Snooze_Cnt), .Missed(Missed)
  );
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;
  always @(negedge Clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      logic [5:0] got;
      e = q.pop_front();
      got = {Sound, EN_SNZ, EN_STOP, Missed, Active_Id, Snooze_Cnt};
      checks++;
      if (e.cyc != cyc || ((got ^ e.want) & e.mask) != 6'b0) begin
        errors++;
        $display("FAIL %s cyc=%0d got snd/snz/stp/miss/id/cnt=%b required=%b (mask %b)",
                 e.nm, cyc, got, e.want, e.mask);
      end
    end
  end
  task automatic c(input logic t, input logic s, input logic p);
    Tick = t; Snooze = s; Stop = p;
    @(posedge Clk); #1;
  endtask
  task automatic ex(input string nm, input bit cs, input logic snd, input logic esnz, input logic estp,
                    input logic miss, input logic id, input logic [1:0] sc);
    q.push_back('{cyc, nm, {cs, 5'b11111}, {snd, esnz, estp, miss, id, sc}});
  endtask
  initial begin
    @(posedge Clk); #1;
    ex("rst0", 1, 0, 0, 0, 0, 0, 0);
    c(0, 0, 0); ex("rst1", 1, 0, 0, 0, 0, 0, 0);
    Reset = 1'b0;
    c(0, 0, 0); ex("idle", 1, 0, 0, 0, 0, 0, 0);
    AA = 2'b11;
    c(0, 0, 0); ex("ring_a0", 1, 1, 1, 1, 0, 0, 0);
    c(0, 0, 1); ex("stop_lock", 1, 0, 0, 0, 0, 0, 0);
    c(0, 0, 0); ex("lock_hold", 1, 0, 0, 0, 0, 0, 0);
    AA = 2'b10;
    c(0, 0, 0); ex("lock_exit", 1, 0, 0, 0, 0, 0, 0);
    c(0, 0, 0); ex("ring_a1", 1, 1, 1, 1, 0, 1, 0);
    c(0, 0, 1); ex("lock_a1", 1, 0, 0, 0, 0, 1, 0);
    AA = 2'b00;
    c(0, 0, 0); ex("idle_a1", 1, 0, 0, 0, 0, 1, 0);
    Mute = 1'b1; AA = 2'b01;
    c(0, 0, 0); ex("mute_idle", 1, 0, 0, 0, 0, 1, 0);
    c(0, 0, 0); ex("mute_idle2", 1, 0, 0, 0, 0, 1, 0);
    Mute = 1'b0;
    c(0, 0, 0); ex("unmute_ring", 1, 1, 1, 1, 0, 0, 0);
    Mute = 1'b1;
    c(0, 0, 0); ex("mute_in_ring", 1, 1, 1, 1, 0, 0, 0);
    Mute = 1'b0;
    for (int i = 0; i < 4; i++) begin
      c(1, 0, 0); c(0, 0, 0); ex("ring_tick", MB, 1, 1, 1, 0, 0, 0);
    end
    c(1, 0, 0); ex("timeout", 1, 0, 0, 0, 1, 0, 0);
    c(0, 0, 0); ex("miss_clear", 1, 0, 0, 0, 0, 0, 0);
    c(0, 0, 0); ex("lock_aa_held", 1, 0, 0, 0, 0, 0, 0);
    AA = 2'b00;
    c(0, 0, 0); ex("idle_after_to", 1, 0, 0, 0, 0, 0, 0);
    AA = 2'b01;
    c(0, 0, 0); ex("ring_e", 1, 1, 1, 1, 0, 0, 0);
    c(1, 0, 0);
    Reset = 1'b1;
    c(0, 1, 0); ex("rst_mid_ring", 1, 0, 0, 0, 0, 0, 0);
    AA = 2'b00;
    c(0, 1, 0); ex("rst_hold", 1, 0, 0, 0, 0, 0, 0);
    Reset = 1'b0;
    c(0, 1, 0); ex("post_rst_idle", 1, 0, 0, 0, 0, 0, 0);
    AA = 2'b01;
    c(0, 1, 0); ex("ring_btn_held", 1, 1, 1, 1, 0, 0, 0);
    c(0, 1, 0); ex("held_no_edge", 1, 1, 1, 1, 0, 0, 0);
    c(0, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      c(0, 1, 0); ex("snooze_enter", 1, 0, 0, 1, 0, 0, 2'(k));
      if (k == 1) begin
        AA = 2'b00;
        c(0, 0, 0); c(0, 1, 0); ex("snz_in_snooze", 1, 0, 0, 1, 0, 0, 2'(k));
      end
      c(0, 0, 0);
      for (int i = 0; i < 3; i++) begin
        c(1, 0, 0); c(0, 0, 0); ex("snoozing", 1, 0, 0, 1, 0, 0, 2'(k));
      end
      c(1, 0, 0); ex("wake", 1, 1, k < 3, 1, 0, 0, 2'(k));
    end
    c(0, 0, 0); c(0, 1, 0); ex("snz_limit", 1, 1, 0, 1, 0, 0, 3);
    c(0, 0, 0); ex("snz_limit2", 1, 1, 0, 1, 0, 0, 3);
    c(0, 0, 1); ex("lock_cnt3", 1, 0, 0, 0, 0, 0, 3);
    c(0, 0, 0);
    AA = 2'b01;
    c(0, 0, 0); ex("ring_g", 1, 1, 1, 1, 0, 0, 0);
    c(0, 1, 0); ex("snooze_g", 1, 0, 0, 1, 0, 0, 1);
    c(0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      c(1, 0, 0); c(0, 0, 0);
    end
    c(1, 0, 1); ex("stop_beats_wake", 1, 0, 0, 0, 0, 0, 1);
    c(0, 0, 0);
    AA = 2'b00;
    c(0, 0, 0);
    AA = 2'b01;
    c(0, 0, 0); ex("ring_h", 1, 1, 1, 1, 0, 0, 0);
    c(0, 1, 1); ex("snz_stp_same", 1, 0, 0, 0, 0, 0, 0);
    c(0, 0, 0);
    AA = 2'b00;
    c(0, 0, 0);
    AA = 2'b01;
    c(0, 0, 0); ex("beep_enter", 1, 1, 1, 1, 0, 0, 0);
    c(1, 0, 0); ex("beep_tick1", 1, !BEEP, 1, 1, 0, 0, 0);
    c(0, 0, 0); ex("beep_hold", 1, !BEEP, 1, 1, 0, 0, 0);
    c(1, 0, 0); ex("beep_tick2", 1, 1, 1, 1, 0, 0, 0);
    c(0, 0, 1); ex("beep_lock", 1, 0, 0, 0, 0, 0, 0);
    c(0, 0, 0); c(0, 0, 0);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
